// File: rtl/fpadd_share_ctrl.sv
// fpadd_share_ctrl: round-robin sharing of one pipelined fp16 adder.
// Optional WAIT watchdog is compiled in with FPADD_SHARE_TIMEOUT_EN.
module fpadd_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               add_enable,
  output logic [15:0]        add_in1,
  output logic [15:0]        add_in2,
  input  logic               add_done,
  input  logic [15:0]        add_sum,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [15:0]        rsp_sum,
  output logic               rsp_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    OPB,
    WAIT,
    RESP
  } state_e;

  typedef logic [$clog2(TIMEOUT+1)-1:0] cnt_t;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [15:0]    b_q, b_d;
  logic [15:0]    in1_q, in1_d;
  logic [15:0]    in2_q, in2_d;
  logic [15:0]    sum_q, sum_d;
  logic           rv_q, rv_d;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic [15:0]     gnt_a, gnt_b;
  int              best;

`ifdef FPADD_SHARE_TIMEOUT_EN
  cnt_t cnt_q, cnt_d;
  logic err_q, err_d;
`endif

  // Closest valid requester at or after rr_q, measured cyclically.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_id  = '0;
    gnt_oh  = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    best    = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] &&
          ((i + NREQ - int'(rr_q)) % NREQ) < best) begin
        best      = (i + NREQ - int'(rr_q)) % NREQ;
        gnt_id    = IDW'(i);
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_a     = req_a[16*i +: 16];
        gnt_b     = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    b_d      = b_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    sum_d    = sum_q;
    rv_d     = rv_q;
`ifdef FPADD_SHARE_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          in1_d   = gnt_a;
          b_d     = gnt_b;
          id_d    = gnt_id;
          rr_d    = (int'(gnt_id) == NREQ-1) ? '0
                                             : gnt_id + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        in2_d   = b_q;
        state_d = OPB;
      end
      OPB: begin
`ifdef FPADD_SHARE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (add_done) begin
          sum_d    = add_sum;
          rsp_id_d = id_q;
          rv_d     = 1'b1;
          state_d  = RESP;
`ifdef FPADD_SHARE_TIMEOUT_EN
        end else if (cnt_q == cnt_t'(TIMEOUT-1)) begin
          sum_d    = 16'h7E00;
          rsp_id_d = id_q;
          rv_d     = 1'b1;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d    = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
`ifdef FPADD_SHARE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      rsp_id_q <= '0;
      b_q      <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      sum_q    <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      b_q      <= b_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      sum_q    <= sum_d;
      rv_q     <= rv_d;
    end
  end

`ifdef FPADD_SHARE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // rst_n gate keeps the grant pulse quiet while reset is held.
  assign req_ready  = (state_q == IDLE && rst_n) ? gnt_oh : '0;
  assign add_enable = (state_q == ISSUE);
  assign add_in1    = in1_q;
  assign add_in2    = in2_q;
  assign rsp_valid  = rv_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_sum    = sum_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpadd_share_ctrl.sv
// tb_fpadd_share_ctrl: random + directed bench with adder stub and
// transaction-level model of the sharing controller.
module tb_fpadd_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 8;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               add_enable;
  logic [15:0]        add_in1;
  logic [15:0]        add_in2;
  logic               add_done;
  logic [15:0]        add_sum;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_sum;
  logic               rsp_err;
  logic               busy;

  fpadd_share_ctrl #(
    .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_enable(add_enable), .add_in1(add_in1),
    .add_in2(add_in2), .add_done(add_done),
    .add_sum(add_sum), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: exact fp16 sums for the directed pairs, a fixed
  // scramble otherwise; the controller only forwards the value.
  function automatic logic [15:0] fp_sum(input logic [15:0] a,
                                         input logic [15:0] b);
    case ({a, b})
      32'h3C00_3C00: return 16'h4000;
      32'h4000_C000: return 16'h0000;
      32'h3C00_4000: return 16'h4200;
      32'h4000_4000: return 16'h4400;
      default:       return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
    endcase
  endfunction

  int          lat;
  bit          stall;
  int          st_ph;
  int          st_cnt;
  logic        st_done;
  logic [15:0] st_in1, st_in2, st_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_ph   <= 0;
      st_cnt  <= 0;
      st_done <= 1'b0;
      st_in1  <= '0;
      st_in2  <= '0;
      st_sum  <= '0;
    end else if (add_enable) begin
      st_done <= 1'b0;
      st_in1  <= add_in1;
      st_ph   <= 1;
    end else if (st_ph == 1) begin
      st_in2 <= add_in2;
      st_cnt <= lat;
      st_ph  <= 2;
    end else if (st_ph == 2) begin
      if (st_cnt <= 1 && !stall) begin
        st_done <= 1'b1;
        st_sum  <= fp_sum(st_in1, st_in2);
        st_ph   <= 0;
      end else if (st_cnt > 1) begin
        st_cnt <= st_cnt - 1;
      end
    end
  end

  assign add_done = st_done;
  assign add_sum  = st_sum;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Literal pins set by the directed tests.
  bit          pin_on = 0;
  int          pin_id;
  logic [15:0] pin_sum;
  bit          pin_err;
  int          pin_g[8];
  int          pin_from = 0;
  int          pin_len = 0;

  // Transaction model: one op in flight, cyclic grant after last.
  int          mptr, since, gcount = 0, g, j;
  bit          mbusy, inflight, resp_on, exp_err;
  int          cur_id;
  logic [15:0] cur_a, cur_b, exp_sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs",
          {req_ready, add_enable, add_in1, add_in2, rsp_valid,
           rsp_id, rsp_sum, rsp_err, busy}, 64'd0);
      mptr = 0; mbusy = 0; inflight = 0; resp_on = 0; since = 0;
    end else begin
      g = -1;
      if (!mbusy)
        for (int k = 0; k < NREQ; k++) begin
          j = (mptr + k) % NREQ;
          if (g < 0 && ((req_valid >> j) & 4'd1) != 0) g = j;
        end
      chk("req_ready", req_ready, g < 0 ? 64'd0 : 64'd1 << g);
      chk("busy", busy, mbusy);
      chk("add_enable", add_enable, inflight && since == 1);
      if (inflight && since == 1) chk("add_in1", add_in1, cur_a);
      if (inflight && since == 2) chk("add_in2", add_in2, cur_b);
      chk("rsp_valid", rsp_valid, resp_on);
      chk("rsp_err", rsp_err, resp_on && exp_err);
      if (resp_on) begin
        chk("rsp_id", rsp_id, cur_id);
        chk("rsp_sum", rsp_sum, exp_sum);
      end
      if (resp_on && rsp_ready) begin
        if (pin_on) begin
          chk("pin_id", rsp_id, pin_id);
          chk("pin_sum", rsp_sum, pin_sum);
          chk("pin_err", rsp_err, pin_err);
        end
        resp_on = 0; inflight = 0; mbusy = 0;
      end else if (inflight && !resp_on) begin
        if (since >= 3 && add_done) begin
          resp_on = 1;
          exp_sum = fp_sum(cur_a, cur_b);
          exp_err = 0;
        end
`ifdef FPADD_SHARE_TIMEOUT_EN
        else if (since >= 3 && since - 2 >= TMO) begin
          resp_on = 1;
          exp_sum = 16'h7E00;
          exp_err = 1;
        end
`endif
        since++;
      end
      if (g >= 0) begin
        if (pin_len > 0 && gcount >= pin_from &&
            gcount < pin_from + pin_len)
          chk("pin_grant", req_ready,
              64'd1 << pin_g[gcount - pin_from]);
        gcount++;
        mbusy = 1; inflight = 1; since = 1;
        cur_id = g;
        cur_a = 16'(req_a >> (16 * g));
        cur_b = 16'(req_b >> (16 * g));
        mptr = (g + 1) % NREQ;
      end
    end
  end

  task automatic fail_hang(input string what);
    $display("FAIL %s: bound expired, wanted handshake", what);
    $fatal(1, "bench stopped on expired wait");
  endtask

  task automatic wait_grant(input int id);
    bit got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = req_ready[id];
    end
    if (!got) fail_hang("grant");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp();
    bit got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = rsp_valid && rsp_ready;
    end
    if (!got) fail_hang("response");
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int id, input logic [15:0] a,
                         input logic [15:0] b);
    req_a[16*id +: 16] = a;
    req_b[16*id +: 16] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic single(input int id, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] s,
                        input bit e);
    pin_id = id; pin_sum = s; pin_err = e; pin_on = 1;
    set_req(id, a, b);
    wait_grant(id);
    wait_resp();
    pin_on = 0;
  endtask

  logic [NREQ-1:0] gv;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; lat = 3; stall = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    single(0, 16'h3C00, 16'h3C00, 16'h4000, 0);
    single(2, 16'h4000, 16'hC000, 16'h0000, 0);

    // Backpressure with another requester waiting.
    pin_id = 3; pin_sum = 16'h4200; pin_err = 0; pin_on = 1;
    rsp_ready = 1'b0;
    set_req(3, 16'h3C00, 16'h4000);
    wait_grant(3);
    set_req(1, 16'h1234, 16'h0042);
    begin
      bit got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        got = rsp_valid;
      end
      if (!got) fail_hang("rsp_valid");
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_resp();
    pin_on = 0;
    wait_grant(1);
    wait_resp();

    // Reset while in WAIT, then 1 and 3 compete from pointer 0.
    lat = 5;
    set_req(1, 16'h0F0F, 16'h7070);
    wait_grant(1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pin_g[0] = 1; pin_g[1] = 3; pin_from = gcount; pin_len = 2;
    set_req(1, 16'h2468, 16'h1357);
    set_req(3, 16'h4000, 16'h4000);
    wait_grant(1);
    wait_resp();
    pin_id = 3; pin_sum = 16'h4400; pin_err = 0; pin_on = 1;
    wait_grant(3);
    wait_resp();
    pin_on = 0; pin_len = 0;

    // All four requesting continuously.
    lat = 3;
    pin_g[0] = 0; pin_g[1] = 1; pin_g[2] = 2; pin_g[3] = 3;
    pin_g[4] = 0; pin_from = gcount; pin_len = 5;
    for (int i = 0; i < NREQ; i++)
      set_req(i, 16'h1100 * 16'(i + 1), 16'h0033 * 16'(i + 2));
    begin
      int n = 0;
      for (int c = 0; c < 400 && n < 5; c++) begin
        @(negedge clk);
        gv = req_ready;
        @(posedge clk); #1;
        if (gv != 0) begin
          n++;
          for (int i = 0; i < NREQ; i++)
            if (gv[i]) begin
              req_a[16*i +: 16] = 16'($urandom);
              req_b[16*i +: 16] = 16'($urandom);
            end
        end
      end
      if (n < 5) fail_hang("fair_grants");
    end
    req_valid = '0;
    wait_resp();
    pin_len = 0;

`ifdef FPADD_SHARE_TIMEOUT_EN
    stall = 1;
    single(2, 16'h1111, 16'h2222, 16'h7E00, 1);
    stall = 0;
`endif

    // Random traffic, forfeits and response backpressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      gv = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gv[i])
          req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(3) == 0)
          set_req(i, 16'($urandom), 16'($urandom));
        else if (req_valid[i] && $urandom_range(39) == 0)
          req_valid[i] = 1'b0;
      end
      rsp_ready = ($urandom_range(2) != 0);
      lat = $urandom_range(5, 3);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    begin
      bit idle = 0;
      for (int c = 0; c < 100 && !idle; c++) begin
        @(negedge clk);
        idle = !busy && !rsp_valid;
      end
      if (!idle) fail_hang("drain");
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpadd_share_ctrl.md
Name: fpadd_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one half-precision pipelined FP adder among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready.
- Drives the adder's two-cycle operand load (in1 on the enable cycle, in2 on the following cycle) and waits for the adder's done.
- Returns the sum, tagged with the requester id, over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 64, WAIT-state watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operand pair valid.
- req_ready  out  NREQ  one-hot grant/accept pulse.
- req_a  in  16*NREQ  operand A, requester i at bits [16i+15:16i].
- req_b  in  16*NREQ  operand B, same packing.
- add_enable  out  1  to adder enable.
- add_in1  out  16  to adder in1.
- add_in2  out  16  to adder in2.
- add_done  in  1  from adder done (level, registered).
- add_sum  in  16  from adder sum.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_id  out  IDW  requester index of the result.
- rsp_sum  out  16  result.
- rsp_err  out  1  watchdog error flag (0 unless the optional feature is compiled in).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0. All outputs 0: req_ready, add_enable, add_in1, add_in2, rsp_valid, rsp_id, rsp_sum, rsp_err, busy.
- States: IDLE, ISSUE, OPB, WAIT, RESP.
- IDLE:
  - Grant the first requester with req_valid=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - On a grant g: pulse req_ready[g] for exactly this cycle (combinational from state and req_valid); latch a_q=req_a[g], b_q=req_b[g], id_q=g; set rr_ptr <= (g+1) mod NREQ; go to ISSUE.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- ISSUE (1 cycle): add_enable=1, add_in1=a_q; go to OPB.
- OPB (1 cycle): add_enable=0, add_in2=b_q; go to WAIT.
- add_in1 and add_in2 are registered outputs and hold their last values otherwise.
- WAIT:
  - add_done is ignored in ISSUE and OPB. It may still be high from the previous operation and clears only after the adder samples enable.
  - add_done=1 in WAIT: capture rsp_sum<=add_sum, rsp_id<=id_q; set rsp_valid; go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_sum are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: clear rsp_valid, go to IDLE. A new grant is possible no earlier than the next cycle.
- Latency:
  - Grant to first WAIT cycle: 3 cycles.
  - WAIT duration follows the adder (exponent alignment plus normalisation; at least 4 cycles).
  - At most one operation in flight; no pipelining of requests.
- Fairness: a continuously requesting set is served in cyclic index order. Max wait per requester is NREQ-1 operations.
- Simultaneous events: req_valid changes outside IDLE are ignored; requesters must hold req_valid and operands until req_ready. A requester dropping req_valid before its grant forfeits the slot.
- rr_ptr wrap: after granting NREQ-1, rr_ptr=0.
- Reset mid-operation: the controller returns to IDLE immediately and the in-flight result is discarded. The adder has no reset, so rst_n is asserted only while the adder is in its idle state or together with adder re-initialisation. The controller performs no recovery.

Optional Feature:
- Macro: FPADD_SHARE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with add_done=0, go to RESP with rsp_sum=16'h7E00, rsp_err=1, rsp_id=id_q.
  - rsp_err clears with rsp_valid on the handshake.
- Undefined: no counter; rsp_err is tied to 0; WAIT is unbounded.

Test Plan:
- Single request on requester 0: a=16'h3C00, b=16'h3C00 -> req_ready[0] pulses once; add_enable high one cycle with add_in1=3C00; add_in2=3C00 the next cycle; rsp_valid with rsp_sum=16'h4000, rsp_id=0.
- Cancellation on requester 2: a=16'h4000, b=16'hC000 -> rsp_sum=16'h0000, rsp_id=2.
- All 4 requesters valid continuously with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id matches its grant.
- Response backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_sum/rsp_id stable, no req_ready pulses, busy=1. Raise rsp_ready -> IDLE next cycle.
- rst_n low for 1 cycle while in WAIT -> all outputs 0 asynchronously, rr_ptr=0. A subsequent request on requester 3 completes normally with the correct sum.
- With FPADD_SHARE_TIMEOUT_EN and TIMEOUT=8, add_done held 0 by the bench -> after 8 WAIT cycles rsp_valid=1, rsp_err=1, rsp_sum=16'h7E00.
